// File: rtl/spram_arb_if.sv
// spram_arb_if -- request/response bundle between requesters and spram_arb.
//
// Signals:
//   req      [channels]                 per-channel access request (level)
//   wren     [channels]                 per-channel write strobe, qualified by req
//   address  [channels*address_width]   channel i at [i*address_width +: address_width]
//   data     [channels*data_width]      channel i at [i*data_width +: data_width]
//   ack      [channels]                 registered one-hot completion flag
//   q        [data_width]               registered read data for the acked access
//   busy                                high while the clear sequencer runs
//
// Modports: master drives requests, slave (the arbiter) drives responses.
interface spram_arb_if #(
  parameter int address_width = 8,
  parameter int data_width    = 8,
  parameter int channels      = 2
);
  logic [channels-1:0]               req;
  logic [channels-1:0]               wren;
  logic [channels*address_width-1:0] address;
  logic [channels*data_width-1:0]    data;
  logic [channels-1:0]               ack;
  logic [data_width-1:0]             q;
  logic                              busy;

  modport master (output req, wren, address, data, input ack, q, busy);
  modport slave  (input req, wren, address, data, output ack, q, busy);
endinterface

// File: rtl/spram_arb.sv
// spram_arb -- single-port RAM shared by up to 8 requesters through a
// round-robin arbiter. One access is granted per enabled edge; the granted
// channel sees its ack bit and read-first data on q one cycle later.
//
// Ports:
//   clock   sole clock, rising edge
//   reset   synchronous, active-high
//   enable  global clock enable; low freezes all state and memory
//   bus     spram_arb_if.slave (req/wren/address/data in, ack/q/busy out)
//
// Optional feature: define SPRAM_ARB_CLEAR_EN to add a post-reset clear
// sequencer that zeroes every word before arbitration starts (busy high
// meanwhile). Without it the RAM keeps its contents across reset and busy
// is tied low.
module spram_arb #(
  parameter int    address_width = 8,
  parameter int    data_width    = 8,
  parameter int    channels      = 2,
  parameter string init_file     = ""
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  spram_arb_if.slave bus
);

  localparam int CH_W  = (channels > 1) ? $clog2(channels) : 1;
  localparam int DEPTH = 2 ** address_width;
  // Last grant resets to the top channel so channel 0 is searched first.
  localparam logic [CH_W-1:0] LAST_RST = CH_W'(channels - 1);

`ifdef SPRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  localparam state_t RST_STATE = ST_CLEAR;
`else
  typedef enum logic {ST_RUN} state_t;
  localparam state_t RST_STATE = ST_RUN;
`endif

  logic [data_width-1:0] mem [DEPTH];

  state_t                   state_q, state_d;
  logic [CH_W-1:0]          last_grant_q, last_grant_d;
  logic [channels-1:0]      ack_q, ack_d;
  logic [data_width-1:0]    q_q, q_d;
`ifdef SPRAM_ARB_CLEAR_EN
  logic [address_width-1:0] clr_addr_q, clr_addr_d;
`endif

  logic                     gnt_vld;
  logic [CH_W-1:0]          gnt_idx;
  logic [address_width-1:0] sel_addr;
  logic [data_width-1:0]    sel_data;
  logic                     mem_we;
  logic [address_width-1:0] mem_waddr;
  logic [data_width-1:0]    mem_wdata;

  // Round-robin search starting just above the previous winner.
  always_comb begin
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = last_grant_q;
    for (int k = 1; k <= channels; k++) begin
      cand = (int'(last_grant_q) + k) % channels;
      if (!gnt_vld && bus.req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  assign sel_addr = bus.address[int'(gnt_idx)*address_width +: address_width];
  assign sel_data = bus.data[int'(gnt_idx)*data_width +: data_width];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ack_d        = ack_q;
    q_d          = q_q;
    mem_we       = 1'b0;
    mem_waddr    = sel_addr;
    mem_wdata    = sel_data;
`ifdef SPRAM_ARB_CLEAR_EN
    clr_addr_d   = clr_addr_q;
`endif
    if (enable) begin
      ack_d = '0;
      if (state_q == ST_RUN) begin
        if (gnt_vld) begin
          ack_d[gnt_idx] = 1'b1;
          q_d            = mem[sel_addr];  // pre-write word: read-first
          last_grant_d   = gnt_idx;
          mem_we         = bus.wren[gnt_idx];
        end
      end
`ifdef SPRAM_ARB_CLEAR_EN
      else begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) state_d = ST_RUN;
      end
`endif
    end
    // An access coinciding with reset is discarded, including its write.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RST_STATE;
      last_grant_q <= LAST_RST;
      ack_q        <= '0;
      q_q          <= '0;
`ifdef SPRAM_ARB_CLEAR_EN
      clr_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      q_q          <= q_d;
`ifdef SPRAM_ARB_CLEAR_EN
      clr_addr_q   <= clr_addr_d;
`endif
    end
  end

  assign bus.ack = ack_q;
  assign bus.q   = q_q;
`ifdef SPRAM_ARB_CLEAR_EN
  assign bus.busy = (state_q == ST_CLEAR);
`else
  assign bus.busy = 1'b0;
`endif

endmodule
